// File: rtl/piso_stream_pkg.sv
// rtl/piso_stream_pkg.sv - shared types and helpers for the piso_stream shifter
//
// Purpose : frame state encoding and the bit-counter width helper used by
//           piso_stream and piso_bitcnt.
// Contents: piso_state_t (IDLE, SHIFT, PARITY), cnt_width()
package piso_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } piso_state_t;

    // Counter must reach WIDTH (one past the last bit index) without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bitcnt.sv
// rtl/piso_bitcnt.sv - frame bit counter with clear/enable and terminal-count flag
//
// Purpose : counts consumed bits of a frame; flags the last data bit.
// Ports   : clk_i    clock
//           rst_ni   synchronous active-low reset
//           clr_i    clear to zero (wins over en_i)
//           en_i     increment by one
//           tc_o     count equals WIDTH-1
module piso_bitcnt
    import piso_stream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_stream.sv
// rtl/piso_stream.sv - parametrised parallel-in/serial-out shifter with load handshake
//
// Purpose : serialises WIDTH-bit words onto so, one bit per shift_en strobe,
//           with valid/ready load, selectable bit order and back-to-back frames.
// Ports   : clk         clock
//           rst_n       synchronous active-low reset
//           par_in      parallel word
//           load_valid  source offers par_in
//           load_ready  word can be taken this cycle
//           shift_en    bit-rate strobe
//           so          serial data
//           so_valid    so carries a frame bit
//           busy        frame in progress
//           done        one-cycle pulse after the final bit is consumed
// Option  : PISO_STREAM_PARITY_EN appends an even-parity bit to each frame.
module piso_stream
    import piso_stream_pkg::*;
#(
    parameter int   WIDTH      = 8,
    parameter int   MSB_FIRST  = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             done
);

    piso_state_t      state_q;
    logic [WIDTH-1:0] q_q;
    logic             done_q;
    logic             tc;
    logic             consume;
    logic             last_data;
    logic             frame_end;
    logic             accept;
`ifdef PISO_STREAM_PARITY_EN
    logic             par_q;
`endif

    assign consume   = (state_q == SHIFT) && shift_en;
    assign last_data = consume && tc;

`ifdef PISO_STREAM_PARITY_EN
    assign frame_end = (state_q == PARITY) && shift_en;
`else
    assign frame_end = last_data;
`endif

    // Ready on the frame's final consume edge lets the next word follow with no gap.
    assign load_ready = (state_q == IDLE) || frame_end;
    assign accept     = load_valid && load_ready;

    piso_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (accept),
        .en_i   (consume),
        .tc_o   (tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            done_q  <= 1'b0;
`ifdef PISO_STREAM_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            done_q <= frame_end;
            if (accept) begin
                state_q <= SHIFT;
                q_q     <= par_in;
`ifdef PISO_STREAM_PARITY_EN
                par_q   <= ^par_in;
`endif
            end else begin
                case (state_q)
                    SHIFT: begin
                        if (shift_en) begin
                            if (MSB_FIRST != 0) begin
                                q_q <= {q_q[WIDTH-2:0], 1'b0};
                            end else begin
                                q_q <= {1'b0, q_q[WIDTH-1:1]};
                            end
                            if (tc) begin
`ifdef PISO_STREAM_PARITY_EN
                                state_q <= PARITY;
`else
                                state_q <= IDLE;
`endif
                            end
                        end
                    end
`ifdef PISO_STREAM_PARITY_EN
                    PARITY: begin
                        if (shift_en) begin
                            state_q <= IDLE;
                        end
                    end
`endif
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_comb begin
        so       = IDLE_LEVEL;
        so_valid = 1'b0;
        if (state_q == SHIFT) begin
            so       = (MSB_FIRST != 0) ? q_q[WIDTH-1] : q_q[0];
            so_valid = 1'b1;
        end
`ifdef PISO_STREAM_PARITY_EN
        else if (state_q == PARITY) begin
            so       = par_q;
            so_valid = 1'b1;
        end
`endif
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_piso_stream.sv
// tb/tb_piso_stream.sv - directed self-checking bench for piso_stream
module tb_piso_stream;

`ifdef PISO_STREAM_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic clk;
    logic rst_n;

    logic [3:0] pin4;
    logic       lv4, sh4, lr4, so4, sv4, busy4, done4;
    logic [7:0] pin8;
    logic       lv8, sh8, lr8, so8, sv8, busy8, done8;

    int checks;
    int failures;

    piso_stream #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .par_in     (pin4),
        .load_valid (lv4),
        .load_ready (lr4),
        .shift_en   (sh4),
        .so         (so4),
        .so_valid   (sv4),
        .busy       (busy4),
        .done       (done4)
    );

    piso_stream #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .par_in     (pin8),
        .load_valid (lv8),
        .load_ready (lr8),
        .shift_en   (sh8),
        .so         (so8),
        .so_valid   (sv8),
        .busy       (busy8),
        .done       (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       lv;
        logic [3:0] pin;
        logic       sh;
        logic       e_so;
        logic       e_sv;
        logic       e_busy;
        logic       e_lr;
        logic       e_done;
    } vec_t;

    vec_t vecs[8];
    int   nvec;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic [7:0] w;
    logic [7:0] words[2];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        lv4 = 1'b0; pin4 = '0; sh4 = 1'b0;
        lv8 = 1'b0; pin8 = '0; sh8 = 1'b0;
        tick();
        tick();

        // reset state
        chk("rst_so4", so4, 1'b0);
        chk("rst_sv4", sv4, 1'b0);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_lr4", lr4, 1'b1);
        chk("rst_done4", done4, 1'b0);
        chk("rst_busy8", busy8, 1'b0);
        chk("rst_lr8", lr8, 1'b1);
        rst_n = 1'b1;

        // LSB-first WIDTH=4, load 1101, shift_en held high
        //            lv   pin      sh   so   sv   busy lr   done
        vecs[0] = '{1'b1, 4'b1101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`ifdef PISO_STREAM_PARITY_EN
        vecs[4] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[7] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        nvec = 8;
`else
        vecs[4] = '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        nvec = 7;
`endif
        for (int i = 0; i < nvec; i++) begin
            lv4 = vecs[i].lv; pin4 = vecs[i].pin; sh4 = vecs[i].sh;
            settle();
            chk($sformatf("t1_so[%0d]", i), so4, vecs[i].e_so);
            chk($sformatf("t1_sv[%0d]", i), sv4, vecs[i].e_sv);
            chk($sformatf("t1_busy[%0d]", i), busy4, vecs[i].e_busy);
            chk($sformatf("t1_lr[%0d]", i), lr4, vecs[i].e_lr);
            chk($sformatf("t1_done[%0d]", i), done4, vecs[i].e_done);
            tick();
        end
        lv4 = 1'b0; sh4 = 1'b0;

        // MSB-first WIDTH=8, load A5, shift_en held high
        w = 8'hA5;
        lv8 = 1'b1; pin8 = w; sh8 = 1'b1;
        tick();
        lv8 = 1'b0;
        for (int b = 0; b < 8 + PAR; b++) begin
            settle();
            chk($sformatf("t2_so[%0d]", b), so8, (b < 8) ? w[7-b] : ^w);
            chk($sformatf("t2_busy[%0d]", b), busy8, 1'b1);
            chk($sformatf("t2_done[%0d]", b), done8, 1'b0);
            tick();
        end
        chk("t2_busy_end", busy8, 1'b0);
        chk("t2_done_end", done8, 1'b1);
        tick();
        chk("t2_done_low", done8, 1'b0);

        // throttled: one strobe every third cycle
        lv8 = 1'b1; pin8 = w; sh8 = 1'b0;
        tick();
        lv8 = 1'b0;
        for (int b = 0; b < 8 + PAR; b++) begin
            for (int k = 0; k < 3; k++) begin
                sh8 = (k == 2);
                settle();
                chk($sformatf("t3_so[%0d.%0d]", b, k), so8, (b < 8) ? w[7-b] : ^w);
                chk($sformatf("t3_sv[%0d.%0d]", b, k), sv8, 1'b1);
                chk($sformatf("t3_done[%0d.%0d]", b, k), done8, 1'b0);
                tick();
            end
        end
        sh8 = 1'b0;
        chk("t3_done_end", done8, 1'b1);
        chk("t3_busy_end", busy8, 1'b0);
        tick();
        chk("t3_done_low", done8, 1'b0);

        // back-to-back F0 then 0F
        words[0] = 8'hF0;
        words[1] = 8'h0F;
        lv8 = 1'b1; pin8 = words[0]; sh8 = 1'b1;
        tick();
        pin8 = words[1];
        for (int f = 0; f < 2; f++) begin
            for (int b = 0; b < 8 + PAR; b++) begin
                w = words[f];
                lv8 = (f == 0);
                settle();
                chk($sformatf("t4_so[%0d.%0d]", f, b), so8, (b < 8) ? w[7-b] : ^w);
                chk($sformatf("t4_sv[%0d.%0d]", f, b), sv8, 1'b1);
                chk($sformatf("t4_lr[%0d.%0d]", f, b), lr8, (b == 8 + PAR - 1));
                chk($sformatf("t4_done[%0d.%0d]", f, b), done8, (f == 1 && b == 0));
                tick();
            end
        end
        lv8 = 1'b0; sh8 = 1'b0;
        chk("t4_done_end", done8, 1'b1);
        chk("t4_sv_end", sv8, 1'b0);
        tick();

        // loads offered mid-frame are ignored
        w = 8'hA5;
        lv8 = 1'b1; pin8 = w; sh8 = 1'b1;
        tick();
        for (int b = 0; b < 8 + PAR; b++) begin
            lv8 = (b >= 1 && b <= 5);
            pin8 = 8'h00;
            settle();
            chk($sformatf("t5i_so[%0d]", b), so8, (b < 8) ? w[7-b] : ^w);
            if (b >= 1 && b <= 5) chk($sformatf("t5i_lr[%0d]", b), lr8, 1'b0);
            tick();
        end
        lv8 = 1'b0;
        chk("t5i_done", done8, 1'b1);
        chk("t5i_busy", busy8, 1'b0);

        // shift_en while idle does nothing
        sh8 = 1'b1;
        tick();
        chk("t5_idle_busy", busy8, 1'b0);
        chk("t5_idle_sv", sv8, 1'b0);

        // reset at bit 3 of a frame
        lv8 = 1'b1; pin8 = 8'hFF; sh8 = 1'b1;
        tick();
        lv8 = 1'b0;
        tick(); tick(); tick();
        settle();
        chk("t5r_busy_pre", busy8, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("t5r_so", so8, 1'b0);
        chk("t5r_sv", sv8, 1'b0);
        chk("t5r_busy", busy8, 1'b0);
        chk("t5r_done", done8, 1'b0);
        chk("t5r_lr", lr8, 1'b1);
        tick();
        chk("t5r_done2", done8, 1'b0);
        chk("t5r_busy2", busy8, 1'b0);
        sh8 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter; next generation of the team's fixed 4-bit PISO register.
- Adds a valid/ready load handshake, selectable bit order and a bit-rate enable (`shift_en`).
- Adds a frame-done pulse and back-to-back frame support.
- Sits between a parallel word source (FIFO/register file) and a serial line driver.

Parameters:
- WIDTH, 8, data word width in bits; legal range is WIDTH ≥ 2.
- MSB_FIRST, 0, sets bit order: 0 = shift out LSB first (right shift), 1 = MSB first (left shift).
- IDLE_LEVEL, 0, value driven on `so` while no frame is active.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- par_in  input  WIDTH  parallel word to serialise.
- load_valid  input  1  source has a word on `par_in`.
- load_ready  output  1  block can accept a word this cycle.
- shift_en  input  1  bit-rate strobe; the current serial bit advances only when this is high.
- so  output  1  serial data out.
- so_valid  output  1  `so` carries a frame bit.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse after the last bit of a frame is consumed.

Behaviour:
- States (shared enum): IDLE, SHIFT, plus PARITY when the optional feature is compiled in.
- Internal state:
  - shift register `q[WIDTH-1:0]`.
  - bit counter `cnt`, width `$clog2(WIDTH+1)`.
  - parity register `par_q` (only with the optional feature).
- Reset (rst_n = 0 at a clock edge):
  - q = 0, cnt = 0, state = IDLE, done = 0.
  - Combinational outputs then give so = IDLE_LEVEL, so_valid = 0, busy = 0, load_ready = 1.
- Reset dominates every other input.
- Reset mid-frame aborts the frame immediately with no `done` pulse.
- Accept: a transfer happens on an edge where `load_valid && load_ready`. Then:
  - q ← par_in, cnt ← 0, state ← SHIFT.
  - The first bit appears on `so` the next cycle.
- so / so_valid:
  - In SHIFT: so = q[0] if MSB_FIRST = 0, else so = q[WIDTH-1]; so_valid = 1.
  - In IDLE: so = IDLE_LEVEL, so_valid = 0.
- Each bit is held until an edge on which shift_en = 1 (bit consumed).
- Bit consumed in SHIFT:
  - q shifts by one; the vacated bit fills with 0.
  - cnt increments.
- Last bit: when cnt == WIDTH-1 and shift_en = 1, the frame ends. On that same edge:
  - done ← 1 for exactly one cycle.
  - state ← SHIFT if a new word is accepted on that edge, otherwise IDLE.
- load_ready = (state == IDLE) || (last-bit consume condition true this cycle).
  - This gives back-to-back frames with zero idle gap.
  - load_ready combinationally depends on shift_en.
- While busy and not on the last bit: load_ready = 0. `par_in` is ignored and the source must hold its word.
- shift_en in IDLE has no effect.
- load_valid while load_ready = 0 has no effect; no data is lost or overwritten.
- busy = (state != IDLE).
- Latency:
  - Accept edge to first bit on `so`: 1 cycle.
  - A frame occupies WIDTH shift_en strobes.
  - `done` is asserted in the cycle after the final consume edge.

Optional Feature:
- Macro: PISO_STREAM_PARITY_EN.
- Defined:
  - At accept, par_q ← even parity of par_in (XOR reduction).
  - After the last data bit is consumed, state ← PARITY: so = par_q, so_valid = 1.
  - A shift_en in PARITY ends the frame; `done` and the back-to-back accept move from the last data bit to this cycle.
  - A frame is WIDTH+1 strobes.
- Undefined: no PARITY state, no par_q register; frame is WIDTH strobes.

Decomposition:
- Package `piso_stream_pkg`:
  - state enum typedef `piso_state_t` (IDLE, SHIFT, PARITY).
  - localparam function for the counter width.
- Sub-module `piso_bitcnt`: a natural split.
  - Parametrised up-counter with clear/enable and a terminal-count flag at WIDTH-1.
  - Instantiated once.
- Shift register and FSM remain in the top module.

Test Plan:
1. Bit order, LSB first: WIDTH = 4, MSB_FIRST = 0, shift_en held at 1, load 4'b1101 → `so` = 1,0,1,1 on consecutive cycles; so_valid high 4 cycles; `done` pulses in cycle 5; load_ready = 1 afterward.
2. Bit order, MSB first: WIDTH = 8, MSB_FIRST = 1, load 8'hA5 → `so` = 1,0,1,0,0,1,0,1; busy high exactly 8 cycles.
3. Throttled shifting: shift_en pulsed every 3rd cycle → each bit held exactly 3 cycles; sequence unchanged; `done` one cycle after the 8th strobe.
4. Back-to-back frames: load_valid held high with 8'hF0 then 8'h0F → 16 contiguous valid bits with no gap; two `done` pulses 8 cycles apart; load_ready high only on the last-bit cycles.
5. Reset and ignored loads:
   - rst_n low at bit 3 of a frame → next cycle so = IDLE_LEVEL, busy = 0, no `done`.
   - load_valid mid-frame → word not taken and frame continues intact.
6. Parity feature: with PISO_STREAM_PARITY_EN, load 4'b1101 → `so` = 1,0,1,1, then parity bit 1; `done` follows the 5th bit.
